// File: rtl/exe_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage_if
// Description : ID/EX inputs and EX/MEM outputs of the execute stage,
//               bundled for connection between pipeline stages.
// Revision    : 1.0  initial release
// ============================================================================
interface exe_stage_if;
    // ID/EX side
    logic        valid_IN;
    logic [31:0] Instr_IN;
    logic [5:0]  ALU_control_IN;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [31:0] readDataB_IN;
    logic [4:0]  writeRegister_IN;
    logic        MemRead_IN;
    logic        MemWrite_IN;
    logic        MemtoReg_IN;
    logic        do_writeback_IN;

    // EX/MEM side
    logic [31:0] aluResult1;
    logic [31:0] readDataB1;
    logic [31:0] Instr1;
    logic [5:0]  ALU_control1;
    logic [4:0]  writeRegister1;
    logic        MemRead1;
    logic        MemWrite1;
    logic        MemtoReg1;
    logic        do_writeback1;
    logic        stall_EX;

    // Upstream driver of the execute stage
    modport master (
        output valid_IN, Instr_IN, ALU_control_IN, operandA, operandB,
               readDataB_IN, writeRegister_IN, MemRead_IN, MemWrite_IN,
               MemtoReg_IN, do_writeback_IN,
        input  aluResult1, readDataB1, Instr1, ALU_control1, writeRegister1,
               MemRead1, MemWrite1, MemtoReg1, do_writeback1, stall_EX
    );

    // The execute stage itself
    modport slave (
        input  valid_IN, Instr_IN, ALU_control_IN, operandA, operandB,
               readDataB_IN, writeRegister_IN, MemRead_IN, MemWrite_IN,
               MemtoReg_IN, do_writeback_IN,
        output aluResult1, readDataB1, Instr1, ALU_control1, writeRegister1,
               MemRead1, MemWrite1, MemtoReg1, do_writeback1, stall_EX
    );
endinterface
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage
// Description : Execute stage: single-cycle ALU, 32x32 multiplier into HI/LO,
//               32-cycle restoring divider that stalls upstream while busy,
//               and the EX/MEM pipeline register.
// Revision    : 1.0  initial release
// ============================================================================
module exe_stage (
    input  wire logic  CLK,
    input  wire logic  RESET,
    exe_stage_if.slave bus
);

    localparam logic [5:0] C_OP_ADD   = 6'b100000;
    localparam logic [5:0] C_OP_SUB   = 6'b100010;
    localparam logic [5:0] C_OP_AND   = 6'b100100;
    localparam logic [5:0] C_OP_OR    = 6'b100101;
    localparam logic [5:0] C_OP_XOR   = 6'b100110;
    localparam logic [5:0] C_OP_NOR   = 6'b101111;
    localparam logic [5:0] C_OP_SLT   = 6'b101000;
    localparam logic [5:0] C_OP_SLTU  = 6'b101001;
    localparam logic [5:0] C_OP_SLL   = 6'b000000;
    localparam logic [5:0] C_OP_SRL   = 6'b000010;
    localparam logic [5:0] C_OP_SRA   = 6'b000011;
    localparam logic [5:0] C_OP_LUI   = 6'b001111;
    localparam logic [5:0] C_OP_MULT  = 6'b011000;
    localparam logic [5:0] C_OP_MULTU = 6'b011001;
    localparam logic [5:0] C_OP_DIV   = 6'b011010;
    localparam logic [5:0] C_OP_DIVU  = 6'b011011;
    localparam logic [5:0] C_OP_MFHI  = 6'b010000;
    localparam logic [5:0] C_OP_MFLO  = 6'b010010;
    localparam logic [5:0] C_DIV_STEPS = 6'd32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_t;

    div_state_t  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    // Divider working registers: partial remainder, dividend/quotient shift
    // register, divisor magnitude, raw dividend (for the divide-by-zero HI).
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, dvnd_q, dvnd_d;
    logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d, by_zero_q, by_zero_d;

    // EX/MEM pipeline register
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] read_data_b_q, read_data_b_d;
    logic [31:0] instr_q, instr_d;
    logic [5:0]  alu_control_q, alu_control_d;
    logic [4:0]  write_register_q, write_register_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        do_writeback_q, do_writeback_d;

    logic [31:0]        w_alu;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_is_mul, w_is_div, w_div_signed;
    logic [32:0]        w_rem_shift, w_rem_sub;
    logic               w_ge;
    logic [31:0]        w_rem_step, w_quo_step;

    assign w_prod_s = $signed({{32{bus.operandA[31]}}, bus.operandA})
                    * $signed({{32{bus.operandB[31]}}, bus.operandB});
    assign w_prod_u = {32'd0, bus.operandA} * {32'd0, bus.operandB};

    assign w_is_mul     = (bus.ALU_control_IN == C_OP_MULT) || (bus.ALU_control_IN == C_OP_MULTU);
    assign w_is_div     = (bus.ALU_control_IN == C_OP_DIV)  || (bus.ALU_control_IN == C_OP_DIVU);
    assign w_div_signed = (bus.ALU_control_IN == C_OP_DIV);

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. A clear borrow bit means it fit.
    assign w_rem_shift = {rem_q, quo_q[31]};
    assign w_rem_sub   = w_rem_shift - {1'b0, dvsr_q};
    assign w_ge        = ~w_rem_sub[32];
    assign w_rem_step  = w_ge ? w_rem_sub[31:0] : w_rem_shift[31:0];
    assign w_quo_step  = {quo_q[30:0], w_ge};

    // Single-cycle ALU result; loads, stores and unknown codes add
    always_comb begin
        w_alu = bus.operandA + bus.operandB;
        case (bus.ALU_control_IN)
            C_OP_ADD:   w_alu = bus.operandA + bus.operandB;
            C_OP_SUB:   w_alu = bus.operandA - bus.operandB;
            C_OP_AND:   w_alu = bus.operandA & bus.operandB;
            C_OP_OR:    w_alu = bus.operandA | bus.operandB;
            C_OP_XOR:   w_alu = bus.operandA ^ bus.operandB;
            C_OP_NOR:   w_alu = ~(bus.operandA | bus.operandB);
            C_OP_SLT:   w_alu = {31'd0, $signed(bus.operandA) < $signed(bus.operandB)};
            C_OP_SLTU:  w_alu = {31'd0, bus.operandA < bus.operandB};
            C_OP_SLL:   w_alu = bus.operandA << bus.operandB[4:0];
            C_OP_SRL:   w_alu = bus.operandA >> bus.operandB[4:0];
            C_OP_SRA:   w_alu = $unsigned($signed(bus.operandA) >>> bus.operandB[4:0]);
            C_OP_LUI:   w_alu = {bus.operandB[15:0], 16'h0000};
            C_OP_MFHI:  w_alu = hi_q;
            C_OP_MFLO:  w_alu = lo_q;
            C_OP_MULT, C_OP_MULTU, C_OP_DIV, C_OP_DIVU: w_alu = 32'd0;
            default:    w_alu = bus.operandA + bus.operandB;
        endcase
    end

    // Next-state for divider FSM, HI/LO and the EX/MEM register
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        dvnd_d    = dvnd_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        by_zero_d = by_zero_q;
        // The EX/MEM register loads a bubble unless an instruction is accepted
        alu_result_d     = 32'd0;
        read_data_b_d    = 32'd0;
        instr_d          = 32'd0;
        alu_control_d    = 6'd0;
        write_register_d = 5'd0;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        mem_to_reg_d     = 1'b0;
        do_writeback_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid_IN) begin
                    alu_result_d     = w_alu;
                    read_data_b_d    = bus.readDataB_IN;
                    instr_d          = bus.Instr_IN;
                    alu_control_d    = bus.ALU_control_IN;
                    write_register_d = bus.writeRegister_IN;
                    mem_read_d       = bus.MemRead_IN;
                    mem_write_d      = bus.MemWrite_IN;
                    mem_to_reg_d     = bus.MemtoReg_IN;
                    // HI/LO producers never write the register file
                    do_writeback_d   = bus.do_writeback_IN & ~(w_is_mul | w_is_div);

                    if (w_is_mul) begin
                        if (bus.ALU_control_IN == C_OP_MULT) begin
                            hi_d = w_prod_s[63:32];
                            lo_d = w_prod_s[31:0];
                        end else begin
                            hi_d = w_prod_u[63:32];
                            lo_d = w_prod_u[31:0];
                        end
                    end

                    if (w_is_div) begin
                        // Divide magnitudes; signs are re-applied at the end
                        quo_d     = (w_div_signed && bus.operandA[31]) ? -bus.operandA : bus.operandA;
                        dvsr_d    = (w_div_signed && bus.operandB[31]) ? -bus.operandB : bus.operandB;
                        rem_d     = 32'd0;
                        dvnd_d    = bus.operandA;
                        q_neg_d   = w_div_signed & (bus.operandA[31] ^ bus.operandB[31]);
                        r_neg_d   = w_div_signed & bus.operandA[31];
                        by_zero_d = (bus.operandB == 32'd0);
                        count_d   = C_DIV_STEPS;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d   = w_rem_step;
                quo_d   = w_quo_step;
                count_d = count_q - 6'd1;
                if (count_q == 6'd1) begin
                    state_d = IDLE;
                    if (by_zero_q) begin
                        hi_d = dvnd_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = r_neg_q ? -w_rem_step : w_rem_step;
                        lo_d = q_neg_q ? -w_quo_step : w_quo_step;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pipeline registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q          <= IDLE;
            count_q          <= 6'd0;
            hi_q             <= 32'd0;
            lo_q             <= 32'd0;
            rem_q            <= 32'd0;
            quo_q            <= 32'd0;
            dvsr_q           <= 32'd0;
            dvnd_q           <= 32'd0;
            q_neg_q          <= 1'b0;
            r_neg_q          <= 1'b0;
            by_zero_q        <= 1'b0;
            alu_result_q     <= 32'd0;
            read_data_b_q    <= 32'd0;
            instr_q          <= 32'd0;
            alu_control_q    <= 6'd0;
            write_register_q <= 5'd0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_to_reg_q     <= 1'b0;
            do_writeback_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            hi_q             <= hi_d;
            lo_q             <= lo_d;
            rem_q            <= rem_d;
            quo_q            <= quo_d;
            dvsr_q           <= dvsr_d;
            dvnd_q           <= dvnd_d;
            q_neg_q          <= q_neg_d;
            r_neg_q          <= r_neg_d;
            by_zero_q        <= by_zero_d;
            alu_result_q     <= alu_result_d;
            read_data_b_q    <= read_data_b_d;
            instr_q          <= instr_d;
            alu_control_q    <= alu_control_d;
            write_register_q <= write_register_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_to_reg_q     <= mem_to_reg_d;
            do_writeback_q   <= do_writeback_d;
        end
    end

    assign bus.aluResult1     = alu_result_q;
    assign bus.readDataB1     = read_data_b_q;
    assign bus.Instr1         = instr_q;
    assign bus.ALU_control1   = alu_control_q;
    assign bus.writeRegister1 = write_register_q;
    assign bus.MemRead1       = mem_read_q;
    assign bus.MemWrite1      = mem_write_q;
    assign bus.MemtoReg1      = mem_to_reg_q;
    assign bus.do_writeback1  = do_writeback_q;
    assign bus.stall_EX       = (state_q == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_stage
// Description : Self-checking bench for exe_stage: directed cases plus a
//               random instruction stream against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_exe_stage;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    int   total = 0;
    int   bad   = 0;

    exe_stage_if bus();
    exe_stage dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100, OR_ = 6'b100101;
    localparam logic [5:0] XOR_ = 6'b100110, NOR_ = 6'b101111, SLT = 6'b101000, SLTU = 6'b101001;
    localparam logic [5:0] SLL = 6'b000000, SRL = 6'b000010, SRA = 6'b000011, LUI = 6'b001111;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
    localparam logic [5:0] MFHI = 6'b010000, MFLO = 6'b010010, LW = 6'b101101;

    // Model state: architectural HI/LO, cycles left on the divider, pending result
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_busy = 0;

    // Expected EX/MEM contents after the next edge
    logic [31:0] e_alu, e_rdb, e_instr;
    logic [5:0]  e_ctl;
    logic [4:0]  e_wr;
    logic        e_mr, e_mw, e_mtr, e_wb, e_stall, e_bubble, e_alu_known;

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic mr, input logic mw, input logic mtr, input logic wb);
        bus.valid_IN         = v;
        bus.ALU_control_IN   = op;
        bus.operandA         = a;
        bus.operandB         = b;
        bus.MemRead_IN       = mr;
        bus.MemWrite_IN      = mw;
        bus.MemtoReg_IN      = mtr;
        bus.do_writeback_IN  = wb;
        bus.Instr_IN         = $urandom | 32'd1;
        bus.readDataB_IN     = $urandom;
        bus.writeRegister_IN = 5'($urandom);
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_busy = 0;
    endtask

    // Predict the effect of the coming edge from the current inputs, then clock
    task automatic tick();
        logic [31:0] a, b;
        logic [63:0] p;
        longint      sa, sb, q, r;
        a = bus.operandA;
        b = bus.operandB;
        e_alu = 0; e_rdb = 0; e_instr = 0; e_ctl = 0; e_wr = 0;
        e_mr = 0; e_mw = 0; e_mtr = 0; e_wb = 0;
        e_bubble = 1; e_alu_known = 1;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (bus.valid_IN) begin
            e_bubble = 0;
            e_instr = bus.Instr_IN; e_rdb = bus.readDataB_IN; e_ctl = bus.ALU_control_IN;
            e_wr = bus.writeRegister_IN; e_mr = bus.MemRead_IN; e_mw = bus.MemWrite_IN;
            e_mtr = bus.MemtoReg_IN; e_wb = bus.do_writeback_IN;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (bus.ALU_control_IN)
                SUB:   e_alu = a - b;
                AND_:  e_alu = a & b;
                OR_:   e_alu = a | b;
                XOR_:  e_alu = a ^ b;
                NOR_:  e_alu = ~(a | b);
                SLT:   e_alu = (sa < sb) ? 32'd1 : 32'd0;
                SLTU:  e_alu = (a < b) ? 32'd1 : 32'd0;
                SLL:   e_alu = a << (b % 32);
                SRL:   e_alu = a >> (b % 32);
                SRA:   begin q = sa >>> (b % 32); e_alu = q[31:0]; end
                LUI:   e_alu = (b % 65536) * 65536;
                MFHI:  e_alu = m_hi;
                MFLO:  e_alu = m_lo;
                MULT:  begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0];
                             e_wb = 0; e_alu_known = 0; end
                MULTU: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0];
                             e_wb = 0; e_alu_known = 0; end
                DIV, DIVU: begin
                    e_wb = 0; e_alu_known = 0; m_busy = 32;
                    if (b == 0) begin
                        p_hi = a; p_lo = 32'hFFFF_FFFF;
                    end else if (bus.ALU_control_IN == DIV) begin
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end else begin
                        p_lo = a / b; p_hi = a % b;
                    end
                end
                default: e_alu = a + b;
            endcase
        end
        e_stall = (m_busy > 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        drive(1, ADD, 32'h1234, 32'h5678, 1, 1, 1, 1);
        #2;
        total++;
        if ({bus.aluResult1, bus.Instr1, bus.readDataB1, bus.ALU_control1, bus.writeRegister1} !== 107'd0) begin
            bad++; $display("FAIL reset_data got alu=%h instr=%h rdb=%h want 0", bus.aluResult1, bus.Instr1, bus.readDataB1);
        end
        total++;
        if ({bus.MemRead1, bus.MemWrite1, bus.MemtoReg1, bus.do_writeback1, bus.stall_EX} !== 5'd0) begin
            bad++; $display("FAIL reset_ctl got %b want 00000",
                            {bus.MemRead1, bus.MemWrite1, bus.MemtoReg1, bus.do_writeback1, bus.stall_EX});
        end
        @(posedge CLK); #1;
        total++;
        if (bus.aluResult1 !== 32'd0 || bus.do_writeback1 !== 1'b0) begin
            bad++; $display("FAIL reset_held got alu=%h wb=%b want 0", bus.aluResult1, bus.do_writeback1);
        end
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_add_overflow();
        drive(1, ADD, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.aluResult1 !== 32'h8000_0000) begin
            bad++; $display("FAIL add_wrap got %h want 80000000", bus.aluResult1);
        end
        total++;
        if (bus.do_writeback1 !== 1'b1) begin
            bad++; $display("FAIL add_wb got %b want 1", bus.do_writeback1);
        end
    endtask

    task automatic test_slt();
        drive(1, SLT, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.aluResult1 !== 32'd1) begin
            bad++; $display("FAIL slt got %h want 1", bus.aluResult1);
        end
        drive(1, SLTU, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.aluResult1 !== 32'd0) begin
            bad++; $display("FAIL sltu got %h want 0", bus.aluResult1);
        end
    endtask

    task automatic test_load();
        drive(1, LW, 32'h1000, 32'hFFFF_FFFC, 1, 0, 1, 1);
        tick();
        total++;
        if (bus.aluResult1 !== 32'h0000_0FFC || bus.MemRead1 !== 1'b1) begin
            bad++; $display("FAIL load_addr got alu=%h mr=%b want 00000ffc 1", bus.aluResult1, bus.MemRead1);
        end
        total++;
        if (bus.Instr1 !== e_instr || bus.writeRegister1 !== e_wr || bus.readDataB1 !== e_rdb) begin
            bad++; $display("FAIL load_pass got instr=%h wr=%0d rdb=%h want %h %0d %h",
                            bus.Instr1, bus.writeRegister1, bus.readDataB1, e_instr, e_wr, e_rdb);
        end
    endtask

    // Runs a division then checks stall length, bubbles and the HI/LO readback
    task automatic test_div(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] want_lo, input logic [31:0] want_hi);
        int stall_cycles = 0;
        int leaks = 0;
        drive(1, op, a, b, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.do_writeback1 !== 1'b0) begin
            bad++; $display("FAIL div_wb got %b want 0", bus.do_writeback1);
        end
        for (int k = 1; k <= 40 && bus.stall_EX === 1'b1; k++) begin
            stall_cycles++;
            drive(1, ($urandom % 2) ? DIV : ADD, $urandom, $urandom, 1, 1, 1, 1);
            tick();
            if ({bus.Instr1, bus.MemRead1, bus.MemWrite1, bus.MemtoReg1, bus.do_writeback1} !== 36'd0) leaks++;
        end
        total++;
        if (stall_cycles != 32) begin
            bad++; $display("FAIL div_stall_len got %0d want 32", stall_cycles);
        end
        total++;
        if (leaks != 0) begin
            bad++; $display("FAIL div_bubble got %0d non-bubble cycles want 0", leaks);
        end
        drive(1, MFLO, 0, 0, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.aluResult1 !== want_lo) begin
            bad++; $display("FAIL div_lo got %h want %h", bus.aluResult1, want_lo);
        end
        drive(1, MFHI, 0, 0, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.aluResult1 !== want_hi) begin
            bad++; $display("FAIL div_hi got %h want %h", bus.aluResult1, want_hi);
        end
    endtask

    task automatic test_mult_then_reset();
        drive(1, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.do_writeback1 !== 1'b0) begin
            bad++; $display("FAIL multu_wb got %b want 0", bus.do_writeback1);
        end
        drive(1, MFHI, 0, 0, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.aluResult1 !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL multu_hi got %h want fffffffe", bus.aluResult1);
        end
        drive(1, MFLO, 0, 0, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.aluResult1 !== 32'd1) begin
            bad++; $display("FAIL multu_lo got %h want 1", bus.aluResult1);
        end
        drive(1, DIV, 32'd100, 32'd7, 0, 0, 0, 1);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1, ADD, $urandom, $urandom, 1, 1, 1, 1);
            tick();
        end
        total++;
        if (bus.stall_EX !== 1'b1) begin
            bad++; $display("FAIL mid_div_stall got %b want 1", bus.stall_EX);
        end
        #2;
        RESET = 1'b1;
        #1;
        total++;
        if (bus.stall_EX !== 1'b0) begin
            bad++; $display("FAIL async_reset_stall got %b want 0", bus.stall_EX);
        end
        total++;
        if ({bus.aluResult1, bus.Instr1, bus.readDataB1, bus.ALU_control1, bus.writeRegister1,
             bus.MemRead1, bus.MemWrite1, bus.MemtoReg1, bus.do_writeback1} !== 111'd0) begin
            bad++; $display("FAIL async_reset_outputs got alu=%h instr=%h wb=%b want 0",
                            bus.aluResult1, bus.Instr1, bus.do_writeback1);
        end
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        drive(1, MFHI, 0, 0, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.aluResult1 !== 32'd0 || bus.Instr1 !== e_instr || bus.stall_EX !== 1'b0) begin
            bad++; $display("FAIL post_reset_hi got alu=%h instr=%h stall=%b want 0 %h 0",
                            bus.aluResult1, bus.Instr1, bus.stall_EX, e_instr);
        end
        drive(1, MFLO, 0, 0, 0, 0, 0, 1);
        tick();
        total++;
        if (bus.aluResult1 !== 32'd0) begin
            bad++; $display("FAIL post_reset_lo got %h want 0", bus.aluResult1);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [16] = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SLT, SLTU,
                                   SLL, SRL, SRA, LUI, MULT, MULTU, MFHI, MFLO};
        logic [5:0]  op;
        logic [31:0] a, b;
        int          r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4)       op = ($urandom % 2) ? DIV : DIVU;
            else if (r < 14) op = 6'($urandom);
            else if (r < 20) op = LW;
            else             op = ops[$urandom % 16];
            a = ($urandom % 6 == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom % 6 == 0) ? 32'd0 : (($urandom % 5 == 0) ? 32'hFFFF_FFFF : $urandom);
            drive($urandom_range(0, 9) != 0, op, a, b, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            total++;
            if (bus.stall_EX !== e_stall) begin
                bad++; $display("FAIL rand_stall[%0d] got %b want %b", i, bus.stall_EX, e_stall);
            end
            total++;
            if ({bus.Instr1, bus.MemRead1, bus.MemWrite1, bus.MemtoReg1, bus.do_writeback1} !==
                {e_instr, e_mr, e_mw, e_mtr, e_wb}) begin
                bad++; $display("FAIL rand_ctl[%0d] got instr=%h ctl=%b want %h %b", i, bus.Instr1,
                                {bus.MemRead1, bus.MemWrite1, bus.MemtoReg1, bus.do_writeback1},
                                e_instr, {e_mr, e_mw, e_mtr, e_wb});
            end
            if (!e_bubble) begin
                total++;
                if ({bus.readDataB1, bus.ALU_control1, bus.writeRegister1} !== {e_rdb, e_ctl, e_wr}) begin
                    bad++; $display("FAIL rand_pass[%0d] got %h %h %h want %h %h %h", i,
                                    bus.readDataB1, bus.ALU_control1, bus.writeRegister1, e_rdb, e_ctl, e_wr);
                end
                if (e_alu_known) begin
                    total++;
                    if (bus.aluResult1 !== e_alu) begin
                        bad++; $display("FAIL rand_alu[%0d] op=%b a=%h b=%h got %h want %h", i,
                                        e_ctl, a, b, bus.aluResult1, e_alu);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_slt();
        test_load();
        test_div(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        test_div(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        test_div(DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
        test_mult_then_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
